// File: rtl/alu_multicycle.sv
// alu_multicycle: RV32I ALU with single-cycle logic/shift/compare ops and
// iterative shift-add multiply and restoring unsigned divide.
// Ports: clk_in, reset_in (sync, active-high); start_in, alu_operation_in,
//   operand_a_in, operand_b_in (request); busy_out, done_out (1-cycle pulse),
//   result_y_out, result_carry_out, zero_out, illegal_op_out (result).
module alu_multicycle #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk_in,
   input  logic             reset_in,
   input  logic             start_in,
   input  logic [3:0]       alu_operation_in,
   input  logic [WIDTH-1:0] operand_a_in,
   input  logic [WIDTH-1:0] operand_b_in,
   output logic             busy_out,
   output logic             done_out,
   output logic [WIDTH-1:0] result_y_out,
   output logic             result_carry_out,
   output logic             zero_out,
   output logic             illegal_op_out
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     a_q, b_q;
   logic [3:0]           op_q;
   logic [SHAMT_W-1:0]   cnt_q;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic                 accept, last;

   logic [SHAMT_W-1:0]   shamt;
   logic [WIDTH-1:0]     sra_res;
   logic [WIDTH:0]       sc_wide;
   logic                 sc_ill;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_sh;
   logic [WIDTH+1:0]     div_diff;

   // ---------------- FSM ----------------
   always_ff @(posedge clk_in) begin
      if (reset_in) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      last    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_in) begin
               accept = 1'b1;
               if (alu_operation_in == 4'hA || alu_operation_in == 4'hB)
                  state_d = S_MUL;
               else if (alu_operation_in == 4'hC || alu_operation_in == 4'hD)
                  state_d = S_DIV;
            end
         end
         S_MUL, S_DIV: begin
            if (cnt_q == SHAMT_W'(WIDTH-1)) begin
               last    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy_out = (state_q != S_IDLE);
   assign zero_out = (result_y_out == '0);

   // ---------------- single-cycle ops ----------------
   assign shamt   = operand_b_in[SHAMT_W-1:0];
   assign sra_res = WIDTH'($signed(operand_a_in) >>> shamt);

   // Non-arithmetic ops are zero-extended so the carry bit stays 0.
   always_comb begin
      sc_wide = '0;
      sc_ill  = 1'b0;
      case (alu_operation_in)
         4'h0: sc_wide = {1'b0, operand_a_in} + {1'b0, operand_b_in};
         4'h1: sc_wide = {1'b0, operand_a_in} + {1'b0, ~operand_b_in}
                         + (WIDTH+1)'(1);
         4'h2: sc_wide = {1'b0, operand_a_in & operand_b_in};
         4'h3: sc_wide = {1'b0, operand_a_in | operand_b_in};
         4'h4: sc_wide = {1'b0, operand_a_in ^ operand_b_in};
         4'h5: sc_wide = {1'b0, operand_a_in << shamt};
         4'h6: sc_wide = {1'b0, operand_a_in >> shamt};
         4'h7: sc_wide = {1'b0, sra_res};
         4'h8: sc_wide = (WIDTH+1)'($signed(operand_a_in) <
                                    $signed(operand_b_in));
         4'h9: sc_wide = (WIDTH+1)'(operand_a_in < operand_b_in);
         4'hE, 4'hF: sc_ill = 1'b1;
         default: sc_wide = '0;
      endcase
   end

   // ---------------- iterative step ----------------
   // MUL: acc = {hi, multiplier}; add multiplicand on lsb, shift right.
   // DIV: acc = {remainder, quotient}; shift left, trial subtract.
   always_comb begin
      acc_d    = acc_q;
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + (acc_q[0] ? {1'b0, a_q} : '0);
      div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff = {1'b0, div_sh} - {2'b0, b_q};
      if (state_q == S_MUL) begin
         acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end else if (state_q == S_DIV) begin
         if (!div_diff[WIDTH+1])
            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         else
            acc_d = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
   end

   // ---------------- datapath / outputs ----------------
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         a_q              <= '0;
         b_q              <= '0;
         op_q             <= '0;
         cnt_q            <= '0;
         acc_q            <= '0;
         done_out         <= 1'b0;
         result_y_out     <= '0;
         result_carry_out <= 1'b0;
         illegal_op_out   <= 1'b0;
      end else begin
         done_out <= 1'b0;
         if (accept) begin
            a_q            <= operand_a_in;
            b_q            <= operand_b_in;
            op_q           <= alu_operation_in;
            cnt_q          <= '0;
            illegal_op_out <= sc_ill;
            if (state_d == S_DIV)
               acc_q <= {{WIDTH{1'b0}}, operand_a_in};
            else if (state_d == S_MUL)
               acc_q <= {{WIDTH{1'b0}}, operand_b_in};
            else begin
               result_y_out     <= sc_wide[WIDTH-1:0];
               result_carry_out <= sc_wide[WIDTH];
               done_out         <= 1'b1;
            end
         end else if (busy_out) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + SHAMT_W'(1);
            if (last) begin
               done_out         <= 1'b1;
               result_carry_out <= 1'b0;
               // MULHU and REMU take the upper half of the accumulator.
               if (op_q == 4'hB || op_q == 4'hD)
                  result_y_out <= acc_d[2*WIDTH-1:WIDTH];
               else
                  result_y_out <= acc_d[WIDTH-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: scoreboard bench for alu_multicycle (WIDTH=32).
// Driver pushes expected results; a negedge monitor pops and compares.
module tb_alu_multicycle;

   logic        clk = 1'b0;
   logic        reset_in;
   logic        start_in;
   logic [3:0]  alu_op;
   logic [31:0] opa, opb;
   logic        busy_out, done_out, carry_out, zero_out, illegal_out;
   logic [31:0] y_out;

   alu_multicycle #(.WIDTH(32)) dut (
      .clk_in           (clk),
      .reset_in         (reset_in),
      .start_in         (start_in),
      .alu_operation_in (alu_op),
      .operand_a_in     (opa),
      .operand_b_in     (opb),
      .busy_out         (busy_out),
      .done_out         (done_out),
      .result_y_out     (y_out),
      .result_carry_out (carry_out),
      .zero_out         (zero_out),
      .illegal_op_out   (illegal_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] y;
      logic        c;
      logic        ill;
      int          dc;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   n_tot    = 0;
   int   n_pass   = 0;
   int   busy_lo  = 0;
   int   busy_hi  = -1;
   int   free_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)",
                    nm, act, exp, cyc);
   endtask

   // Reference model straight from the op definitions.
   function automatic exp_t model(input logic [3:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t        e;
      logic [63:0] p;
      logic [4:0]  sh;
      e.y = '0; e.c = 1'b0; e.ill = 1'b0; e.dc = 0;
      sh = b[4:0];
      p  = 64'(a) * 64'(b);
      case (op)
         4'h0: {e.c, e.y} = {1'b0, a} + {1'b0, b};
         4'h1: begin e.y = a - b; e.c = (a >= b); end
         4'h2: e.y = a & b;
         4'h3: e.y = a | b;
         4'h4: e.y = a ^ b;
         4'h5: e.y = a << sh;
         4'h6: e.y = a >> sh;
         4'h7: e.y = $unsigned($signed(a) >>> sh);
         4'h8: e.y = {31'b0, $signed(a) < $signed(b)};
         4'h9: e.y = {31'b0, a < b};
         4'hA: e.y = p[31:0];
         4'hB: e.y = p[63:32];
         4'hC: e.y = (b == 0) ? 32'hFFFF_FFFF : a / b;
         4'hD: e.y = (b == 0) ? a : a % b;
         default: e.ill = 1'b1;
      endcase
      return e;
   endfunction

   task automatic wait_free();
      while (cyc < free_cyc) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      exp_t e;
      int   lat;
      wait_free();
      @(negedge clk);
      alu_op = op; opa = a; opb = b; start_in = 1'b1;
      @(posedge clk); #1;
      start_in = 1'b0;
      opa = $urandom; opb = $urandom; alu_op = 4'($urandom);
      lat = (op >= 4'hA && op <= 4'hD) ? 32 : 0;
      e = model(op, a, b);
      e.dc = cyc + lat;
      if (lat != 0) begin
         busy_lo = cyc;
         busy_hi = cyc + 31;
      end
      free_cyc = e.dc;
      sb.push_back(e);
   endtask

   // Monitor: busy every cycle, result whenever done_out is seen.
   always @(negedge clk) begin
      if (reset_in === 1'b0) begin
         chk("busy", {31'b0, busy_out},
             {31'b0, (cyc >= busy_lo && cyc <= busy_hi)});
         if (done_out) begin
            if (sb.size() == 0) begin
               chk("spurious_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("done_cycle", cyc, e.dc);
               chk("y", y_out, e.y);
               chk("carry", {31'b0, carry_out}, {31'b0, e.c});
               chk("zero", {31'b0, zero_out}, {31'b0, e.y == 0});
               chk("illegal", {31'b0, illegal_out}, {31'b0, e.ill});
            end
         end else if (sb.size() > 0 && cyc > sb[0].dc) begin
            chk("missing_done", 32'd0, 32'd1);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0]  op;
      logic [31:0] a, b;
      reset_in = 1'b1; start_in = 1'b0;
      alu_op = '0; opa = '0; opb = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_y", y_out, 32'h0);
      chk("rst_done", {31'b0, done_out}, 32'h0);
      chk("rst_busy", {31'b0, busy_out}, 32'h0);
      chk("rst_illegal", {31'b0, illegal_out}, 32'h0);
      @(negedge clk) reset_in = 1'b0;

      issue(4'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(4'h1, 32'h1, 32'h2);
      issue(4'h1, 32'hFFFF_FF9C, 32'hFFFF_FFFE);
      issue(4'h7, 32'h8000_0000, 32'h24);
      issue(4'h8, 32'hFFFF_FF9C, 32'h2);
      issue(4'h9, 32'hFFFF_FF9C, 32'h2);
      issue(4'hA, 32'h0001_0000, 32'h0001_0000);
      issue(4'hB, 32'h0001_0000, 32'h0001_0000);
      issue(4'hC, 32'd100, 32'd7);
      issue(4'hD, 32'd100, 32'd7);
      issue(4'hC, 32'd5, 32'd0);
      issue(4'hD, 32'd5, 32'd0);
      issue(4'hF, 32'h1234, 32'h5678);
      issue(4'h0, 32'd2, 32'd1);

      // A start while busy must be ignored.
      issue(4'hA, 32'h0001_0000, 32'h0001_0000);
      repeat (4) @(posedge clk);
      @(negedge clk);
      alu_op = 4'h0; opa = 32'd1; opb = 32'd1; start_in = 1'b1;
      @(posedge clk); #1;
      start_in = 1'b0;

      // Reset in the middle of a multiply aborts it.
      issue(4'hA, 32'hDEAD_BEEF, 32'h1234_5678);
      repeat (8) @(posedge clk);
      @(negedge clk) reset_in = 1'b1;
      @(posedge clk); #1;
      chk("abort_y", y_out, 32'h0);
      chk("abort_carry", {31'b0, carry_out}, 32'h0);
      chk("abort_busy", {31'b0, busy_out}, 32'h0);
      chk("abort_done", {31'b0, done_out}, 32'h0);
      sb.delete();
      busy_hi = -1; free_cyc = 0;
      @(negedge clk) reset_in = 1'b0;
      issue(4'h0, 32'd40, 32'd2);

      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
         if ($urandom_range(0, 7) == 0) b = 32'h0;
         issue(op, a, b);
      end

      wait_free();
      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
